// File: rtl/spi_mem_master.sv
// rtl/spi_mem_master.sv - host-side sequencer for SPIwrap byte read/write transactions
module spi_mem_master #(
    parameter int ADDR_W      = 8,
    parameter int GAP_CYCLES  = 1,
    parameter int TURN_CYCLES = 2,
    parameter int ADDR_CACHE  = 0
) (
    input  logic              SCK,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP,
        S_DATA,
        S_TURN,
        S_SHIFT,
        S_END
    } state_t;

    localparam logic [3:0] FRM_LAST   = 4'(ADDR_W + 3);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] SHIFT_LAST = 4'(ADDR_W - 1);

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q, wdata_q, sh_q, rdata_nxt;
    logic [ADDR_W-1:0]   cache_addr;
    logic                cache_vld;
    logic                accept, hit;
    logic [ADDR_W+3:0]   afrm, dfrm;
    logic                ss_n_d, mosi_d, rsp_valid_d;

    assign accept = req_valid && req_ready;
    assign hit    = (ADDR_CACHE != 0) && cache_vld && (cache_addr == req_addr);

    // Frame word = start bit, 3-bit command, payload; shifted out MSB first.
    assign afrm = {1'b0, (wr_q ? 3'b000 : 3'b110), addr_q};
    assign dfrm = {1'b0, (wr_q ? 3'b001 : 3'b111), (wr_q ? wdata_q : {ADDR_W{1'b0}})};

    assign rdata_nxt = (state == S_SHIFT) ? {sh_q[ADDR_W-2:0], MISO} : sh_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 4'd1;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = hit ? S_DATA : S_ADDR;
            end
            S_ADDR: if (cnt == FRM_LAST) begin
                state_nxt = S_GAP;
                cnt_nxt   = '0;
            end
            S_GAP: if (cnt == GAP_LAST) begin
                state_nxt = S_DATA;
                cnt_nxt   = '0;
            end
            S_DATA: if (cnt == FRM_LAST) begin
                state_nxt = wr_q ? S_END : S_TURN;
                cnt_nxt   = '0;
            end
            S_TURN: if (cnt == TURN_LAST) begin
                state_nxt = S_SHIFT;
                cnt_nxt   = '0;
            end
            S_SHIFT: if (cnt == SHIFT_LAST) begin
                state_nxt = S_END;
                cnt_nxt   = '0;
            end
            S_END: if (cnt == GAP_LAST) begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs are decoded from the next state so every pin comes straight off a flop.
        ss_n_d = !(state_nxt inside {S_ADDR, S_DATA, S_TURN, S_SHIFT});
        mosi_d = 1'b0;
        if (state_nxt == S_ADDR)
            mosi_d = afrm[FRM_LAST - cnt_nxt];
        else if (state_nxt == S_DATA)
            mosi_d = dfrm[FRM_LAST - cnt_nxt];
        rsp_valid_d = (state_nxt == S_END) && (cnt_nxt == GAP_LAST);
    end

    always_ff @(posedge SCK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            SS_n       <= 1'b1;
            MOSI       <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            cache_vld  <= 1'b0;
            cache_addr <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sh_q       <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            SS_n      <= ss_n_d;
            MOSI      <= mosi_d;
            req_ready <= (state_nxt == S_IDLE);
            busy      <= (state_nxt != S_IDLE);
            rsp_valid <= rsp_valid_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == S_ADDR && cnt == FRM_LAST) begin
                cache_vld  <= 1'b1;
                cache_addr <= addr_q;
            end
            sh_q <= rdata_nxt;
            // Publish only on completion so rsp_rdata holds across a read in flight.
            if (rsp_valid_d && !wr_q)
                rsp_rdata <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// tb/tb_spi_mem_master.sv - bench for spi_mem_master with a behavioural SPIwrap slave and memory model
module tb_spi_mem_master;

    localparam int G0 = 1;
    localparam int T0 = 2;
    localparam int G1 = 3;
    localparam int T1 = 4;

    typedef struct packed {
        logic [1:0] unit;
        logic [2:0] cmd;
        logic [7:0] pay;
        logic [7:0] len;
        logic       tail_nz;
        logic       start;
    } frame_t;

    logic            sck = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_write;
    logic [1:0]      req_ready, rsp_valid, busy, ss_n, mosi;
    logic [1:0]      miso = 2'b00;
    logic [1:0][7:0] req_addr, req_wdata, rsp_rdata;

    always #5 sck = ~sck;

    spi_mem_master #(.ADDR_W(8), .GAP_CYCLES(G0), .TURN_CYCLES(T0), .ADDR_CACHE(0)) u_dut0 (
        .SCK(sck), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_mem_master #(.ADDR_W(8), .GAP_CYCLES(G1), .TURN_CYCLES(T1), .ADDR_CACHE(1)) u_dut1 (
        .SCK(sck), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
    );

    // Slave side: decodes frames, owns the memory, drives MISO, logs every frame.
    bit   [7:0] smem [2][256];
    bit   [7:0] saddr [2];
    bit   [7:0] rdb [2];
    int         fcnt [2]    = '{0, 0};
    logic [11:0] fbits [2]  = '{12'd0, 12'd0};
    logic       tnz [2]     = '{1'b0, 1'b0};
    int         hi_run [2]  = '{0, 0};
    int         min_gap [2] = '{255, 255};
    logic       seen [2]    = '{1'b0, 1'b0};
    int         xcnt        = 0;
    frame_t     frq [$];
    logic       pl_go = 1'b0;
    int         pl_u  = 0;
    logic [7:0] pl_a  = 8'd0;
    logic [7:0] pl_d  = 8'd0;

    always @(posedge sck) begin
        if (pl_go) smem[pl_u][pl_a] <= pl_d;
        for (int u = 0; u < 2; u++) begin
            int          c, tt, k;
            logic [11:0] fb;
            frame_t      f;
            c  = fcnt[u];
            tt = (u == 0) ? T0 : T1;
            fb = {fbits[u][10:0], mosi[u]};
            if ($isunknown({mosi[u], ss_n[u]})) xcnt <= xcnt + 1;
            if (ss_n[u] === 1'b0) begin
                if (c == 0 && seen[u] && hi_run[u] < min_gap[u]) min_gap[u] <= hi_run[u];
                hi_run[u] <= 0;
                fcnt[u]   <= c + 1;
                if (c < 12) fbits[u] <= fb;
                else if (mosi[u] !== 1'b0) tnz[u] <= 1'b1;
                if (c == 11) begin
                    case (fb[10:8])
                        3'b000, 3'b110: saddr[u] <= fb[7:0];
                        3'b001:         smem[u][saddr[u]] <= fb[7:0];
                        3'b111:         rdb[u] <= smem[u][saddr[u]];
                        default: ;
                    endcase
                end
                k = c + 1 - 12 - tt;
                miso[u] <= (c >= 12 && fbits[u][10:8] == 3'b111 && k >= 0 && k < 8) ? rdb[u][3'(7 - k)] : 1'b0;
            end else begin
                if (c != 0) begin
                    f.unit    = 2'(u);
                    f.start   = fbits[u][11];
                    f.cmd     = fbits[u][10:8];
                    f.pay     = fbits[u][7:0];
                    f.len     = 8'(c);
                    f.tail_nz = tnz[u];
                    frq.push_back(f);
                    seen[u] <= 1'b1;
                end
                fcnt[u] <= 0;
                tnz[u]  <= 1'b0;
                miso[u] <= 1'b0;
                if (hi_run[u] < 1000) hi_run[u] <= hi_run[u] + 1;
            end
        end
    end

    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    bit   [7:0] exp_mem [2][256];
    bit         cvalid [2];
    bit   [7:0] caddr [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t mkf(input int u, input logic [2:0] cmd, input logic [7:0] pay, input int len);
        frame_t f;
        f.unit    = 2'(u);
        f.start   = 1'b0;
        f.cmd     = cmd;
        f.pay     = pay;
        f.len     = 8'(len);
        f.tail_nz = 1'b0;
        return f;
    endfunction

    // One host transaction; expectations come from the protocol rules and the memory model.
    task automatic run_txn(input int u, input bit wr, input bit [7:0] a, input bit [7:0] d, input bit hold);
        int       base, n, g, t, explen, nexp, idx;
        bit       hit;
        bit [7:0] rexp;
        g      = (u == 0) ? G0 : G1;
        t      = (u == 0) ? T0 : T1;
        hit    = (u == 1) && cvalid[u] && (caddr[u] == a);
        explen = (hit ? 0 : 12 + g) + 12 + (wr ? 0 : t + 8) + g;
        rexp   = exp_mem[u][a];
        base   = frq.size();
        req_write[u] = wr;
        req_addr[u]  = a;
        req_wdata[u] = d;
        req_valid[u] = 1'b1;
        n = 0;
        while (req_ready[u] !== 1'b1 && n < 200) begin
            @(negedge sck);
            n++;
        end
        chk("accept_wait", 32'(n < 200), 1);
        @(posedge sck);
        @(negedge sck);
        req_valid[u] = hold;
        req_write[u] = 1'($urandom);
        req_addr[u]  = 8'($urandom);
        req_wdata[u] = 8'($urandom);
        chk("busy_set", 32'(busy[u]), 1);
        chk("ready_low", 32'(req_ready[u]), 0);
        chk("ss_fall", 32'(ss_n[u]), 0);
        n = 1;
        while (rsp_valid[u] !== 1'b1 && n < 400) begin
            @(negedge sck);
            n++;
        end
        chk("txn_len", n, explen);
        if (!wr) chk("rdata", 32'(rsp_rdata[u]), 32'(rexp));
        if (wr) exp_mem[u][a] = d;
        if (!hit) begin
            cvalid[u] = 1'b1;
            caddr[u]  = a;
        end
        @(negedge sck);
        chk("rsp_pulse", 32'(rsp_valid[u]), 0);
        chk("ready_back", 32'(req_ready[u]), 1);
        chk("busy_clr", 32'(busy[u]), 0);
        if (!wr) chk("rdata_hold", 32'(rsp_rdata[u]), 32'(rexp));
        nexp = hit ? 1 : 2;
        chk("frame_cnt", frq.size() - base, nexp);
        if (frq.size() - base == nexp) begin
            idx = base;
            if (!hit) begin
                chk("addr_frame", 32'(frq[idx]), 32'(mkf(u, wr ? 3'b000 : 3'b110, a, 12)));
                idx++;
            end
            chk("data_frame", 32'(frq[idx]), 32'(mkf(u, wr ? 3'b001 : 3'b111, wr ? d : 8'h00, wr ? 12 : 12 + t + 8)));
        end
    endtask

    bit [7:0] ha [4];
    bit [7:0] hd [4];
    bit [7:0] last_a;
    bit [7:0] ra, rd;
    bit       rw;
    int       n;

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge sck);
        rst_n = 1'b1;
        @(negedge sck);
        chk("rst_ss_n", 32'(ss_n), 32'(2'b11));
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_ready", 32'(req_ready), 32'(2'b11));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);

        run_txn(0, 1'b1, 8'h3C, 8'hA5, 1'b0);
        chk("slave_mem_3c", 32'(smem[0][8'h3C]), 32'h A5);

        pl_u = 0; pl_a = 8'h81; pl_d = 8'h5A; pl_go = 1'b1;
        @(posedge sck);
        #1 pl_go = 1'b0;
        exp_mem[0][8'h81] = 8'h5A;
        @(negedge sck);
        run_txn(0, 1'b0, 8'h81, 8'h00, 1'b0);

        run_txn(1, 1'b1, 8'h20, 8'h11, 1'b0);
        run_txn(1, 1'b0, 8'h20, 8'h00, 1'b0);
        run_txn(1, 1'b0, 8'h21, 8'h00, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ha[i] = 8'(8'h90 + i * 8 + $urandom_range(0, 7));
            hd[i] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) run_txn(0, 1'b1, ha[i], hd[i], 1'b1);
        for (int i = 0; i < 4; i++) run_txn(0, 1'b0, ha[i], 8'h00, i != 3);
        req_valid[0] = 1'b0;

        // Abort a write in cycle 6 of its data frame.
        req_write[0] = 1'b1; req_addr[0] = 8'h3C; req_wdata[0] = 8'hFF; req_valid[0] = 1'b1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 200) begin
            @(negedge sck);
            n++;
        end
        @(posedge sck);
        @(negedge sck);
        req_valid[0] = 1'b0;
        repeat (19) @(negedge sck);
        chk("pre_rst_ss_n", 32'(ss_n[0]), 0);
        chk("pre_rst_mosi", 32'(mosi[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ss_n", 32'(ss_n[0]), 1);
        chk("arst_mosi", 32'(mosi[0]), 0);
        chk("arst_busy", 32'(busy[0]), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge sck);
            chk("arst_no_rsp", 32'(rsp_valid), 0);
        end
        #2 rst_n = 1'b1;
        cvalid[0] = 1'b0;
        cvalid[1] = 1'b0;
        @(negedge sck);
        chk("post_rst_ready", 32'(req_ready), 32'(2'b11));
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_no_rsp", 32'(rsp_valid), 0);
        run_txn(1, 1'b0, 8'h21, 8'h00, 1'b0);
        run_txn(0, 1'b0, 8'h3C, 8'h00, 1'b0);

        last_a = 8'h20;
        for (int i = 0; i < 1000; i++) begin
            rw = 1'($urandom);
            ra = ($urandom_range(0, 1) == 1) ? last_a : 8'($urandom_range(0, 15));
            rd = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge sck);
            run_txn(1, rw, ra, rd, 1'b0);
            last_a = ra;
        end

        chk("mosi_never_x", xcnt, 0);
        chk("min_gap0", 32'(min_gap[0] >= G0), 1);
        chk("min_gap1", 32'(min_gap[1] >= G1), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
- Host-side controller that sequences byte read/write transactions to the SPI slave memory block (SPIwrap) over its 4-wire interface.
- Converts a single-beat host request into the two-frame serial protocol: an address frame followed by a data frame.
- Sits between an on-chip requester and the SPIwrap pins (MOSI, SS_n, MISO), sharing SPIwrap's SCK.
- Optionally skips the address frame when the target address is unchanged.

Parameters:
- ADDR_W, 8, address/payload width; fixed protocol width, other values unsupported.
- GAP_CYCLES, 1, minimum cycles SS_n is held high between frames (range 1-15).
- TURN_CYCLES, 2, idle cycles after the read-data command payload before the first MISO bit (range 1-7).
- ADDR_CACHE, 0, 1 = omit the address frame when req_addr equals the last address sent.

Ports:
- SCK in 1: the single clock, rising-edge; same SCK that drives SPIwrap.
- rst_n in 1: asynchronous, active-low reset.
- req_valid in 1: host request valid.
- req_ready out 1: high only in IDLE; request accepted on a rising edge with req_valid&&req_ready.
- req_write in 1: 1 = write, 0 = read.
- req_addr in 8: target address.
- req_wdata in 8: write data; ignored for reads.
- rsp_valid out 1: one-cycle pulse when a transaction completes (reads and writes).
- rsp_rdata out 8: read data; holds its value until the next read completes.
- busy out 1: high from acceptance until rsp_valid.
- SS_n out 1: slave select, active-low.
- MOSI out 1: serial data to the slave.
- MISO in 1: serial data from the slave.

Behaviour:
- Clocking: all logic on posedge SCK; all outputs registered. A value driven at edge k is sampled by the slave at edge k+1.
- Reset values: SS_n=1, MOSI=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, address cache invalid.
- Frame, counted in cycles from SS_n falling:
  - cycle 0: start bit, always 0.
  - cycles 1-3: 3-bit command, MSB first.
  - cycles 4-11: 8-bit payload, MSB first.
  - SS_n returns high after cycle 11.
- Command codes: 000 write-address, 001 write-data, 110 read-address, 111 read-data.
- Read-data frame extensions:
  - Payload is 8 dummy bits, MOSI=0.
  - Then TURN_CYCLES cycles with MOSI=0.
  - Then 8 MISO samples, MSB first, one per rising edge.
  - SS_n rises the cycle after the last sample.
- State machine:
  - IDLE: on accept, latch addr/wdata/write → ADDR_FRM.
  - If ADDR_CACHE=1 and the cache is valid and matches the latched address, skip directly to DATA_FRM. This applies for both reads and writes.
  - ADDR_FRM: cmd 000 (write) or 110 (read), payload = addr → GAP.
  - GAP: SS_n=1, MOSI=0 for GAP_CYCLES → DATA_FRM.
  - DATA_FRM: write: cmd 001, payload = wdata → END. Read: cmd 111, dummy payload → TURN.
  - TURN: TURN_CYCLES cycles → SHIFT.
  - SHIFT: 8 samples into rsp_rdata shift register → END.
  - END: SS_n=1 for GAP_CYCLES, rsp_valid pulses on the final END cycle → IDLE.
- Address cache: updated with addr at the end of every ADDR_FRM; invalidated only by reset. The slave is defined not to auto-increment its address.
- Durations, SS_n fall to rsp_valid inclusive (GAP=1, TURN=2, no cache hit):
  - Write: 12+1+12+1 = 26 cycles.
  - Read: 12+1+22+1 = 36 cycles.
  - A cache hit removes 13 cycles.
- Back-to-back: req_ready rises the cycle after rsp_valid, so the earliest next SS_n fall is 1 cycle later. SS_n-high spacing between frames is therefore always ≥ GAP_CYCLES.
- Simultaneous events: req_valid while busy is not accepted and is ignored (no queueing). Request inputs may change after acceptance without effect.
- Reset mid-frame: SS_n goes high immediately (async), any in-flight frame is abandoned, and no rsp_valid is issued. The slave treats the SS_n rise as frame abort.
- Host-side only: no X on MOSI at any time.

Test Plan:
- Write 0xA5 to addr 0x3C → MOSI sequence 0,000,00111100, SS_n high 1 cycle, then 0,001,10100101. rsp_valid 26 cycles after SS_n fall. SPIwrap mem[0x3C]==0xA5.
- Preload mem[0x81]=0x5A, read addr 0x81 → frames 0,110,10000001 then 0,111,00000000, 2 turn cycles, 8 samples. rsp_rdata==0x5A with rsp_valid at cycle 36.
- ADDR_CACHE=1: write 0x11 to 0x20, then read 0x20 → second transaction emits only the 111 frame and returns 0x11. Then read 0x21 → full two-frame sequence.
- req_valid held high continuously for 4 random writes then 4 readbacks → each accepted only in IDLE. SS_n-high gaps ≥1 cycle. All readbacks match the written data.
- rst_n asserted at cycle 6 of a data frame → SS_n=1 and MOSI=0 asynchronously, no rsp_valid. After release: req_ready=1, cache invalid, and the next transaction completes normally.
- 1000 random read/write mixes vs. a scoreboard model of mem → zero mismatches, and frame length matches the formulas for GAP_CYCLES=3, TURN_CYCLES=4.
